// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiplier and divider in the integer execute path.
// Both units use the same operand width, state encoding and magnitude helper.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    // The most negative value maps to itself, which is its correct unsigned magnitude.
    function automatic logic [DEF_WIDTH-1:0] abs_mag(input logic [DEF_WIDTH-1:0] x,
                                                     input logic                 sgn);
        return (sgn && x[DEF_WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/seq_multiplier32.sv
// Iterative radix-2 shift-add multiplier: magnitudes are multiplied over WIDTH cycles,
// and the sign is applied to the 2*WIDTH-bit product in a single fix-up cycle.
module seq_multiplier32
    import muldiv_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [DEF_WIDTH-1:0] A,
    input  logic [DEF_WIDTH-1:0] B,
    output logic [2*DEF_WIDTH-1:0] P,
    output logic                 busy,
    output logic                 done
);

    localparam int WIDTH = DEF_WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_e      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   acc_hi_q;
    logic [WIDTH-1:0]   acc_lo_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] p_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH-1:0] prod_d;

    // The adder keeps its carry so the shift below can feed it into the top bit.
    assign sum_d  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign prod_d = neg_q ? (~{acc_hi_q, acc_lo_q} + 1'b1) : {acc_hi_q, acc_lo_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            neg_q    <= 1'b0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_q  <= abs_mag(A, is_signed);
                        acc_lo_q <= abs_mag(B, is_signed);
                        acc_hi_q <= '0;
                        neg_q    <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        cnt_q    <= CNT_W'(WIDTH - 1);
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    {acc_hi_q, acc_lo_q} <= {sum_d, acc_lo_q[WIDTH-1:1]};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    p_q     <= prod_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign P    = p_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/seq_multiplier32.md
# seq_multiplier32

Iterative radix-2 shift-add multiplier, the companion of the team's sequential 32-bit divider in the integer execute path. It accepts two 32-bit operands on a start strobe and computes in WIDTH cycles. It produces a 2*WIDTH-bit product, either signed or unsigned, and holds the result until the next operation is accepted. It is sized and sequenced like the divider so the issue logic can share one multi-cycle scheduling scheme.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  request; sampled only when not busy.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- A  input  WIDTH  multiplicand; sampled with start.
- B  input  WIDTH  multiplier; sampled with start.
- P  output  2*WIDTH  product; valid when done=1, held until next accepted start.
- busy  output  1  high in RUN and FIX states.
- done  output  1  one-cycle pulse when P becomes valid.

## Operation
- States: IDLE, RUN, FIX, DONE. Reset forces IDLE.
- Accept: start=1 while in IDLE or DONE.
  - On accept, latch mcand = |A|, acc_lo = |B|, acc_hi = 0, and neg = is_signed & (A[MSB] ^ B[MSB]).
  - In unsigned mode the magnitude is the raw value.
  - |x| for the most negative value (0x80000000) is 0x80000000 as an unsigned WIDTH-bit value; no overflow.
  - Set cnt = WIDTH-1 and go to RUN.
- RUN, every cycle:
  - sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : 0), WIDTH+1 bits.
  - {acc_hi, acc_lo} <= {sum, acc_lo} >> 1, i.e. the carry enters the top bit.
  - cnt decrements. When cnt==0 in RUN, go to FIX.
- FIX: P <= neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo}, computed mod 2^(2*WIDTH). Then go to DONE.
- DONE: done=1 for this cycle only.
  - With no start, go to IDLE next cycle.
  - With start, accept immediately, as from IDLE.
- start in RUN or FIX is ignored: no queueing, and operands are not re-sampled.
- Operand changes after acceptance have no effect.
- Reset mid-operation: the operation is abandoned, state = IDLE, P = 0, and no done pulse is issued.
- Zero operands need no special path; the result is 0 with the same latency.

## Timing
- Reset values: P=0, busy=0, done=0, state IDLE, internal registers 0.
- Start accepted at edge 0 → RUN for WIDTH edges → FIX for 1 edge → done=1 visible after edge WIDTH+1.
  - Latency is WIDTH+2 cycles from the start cycle to the done cycle, 34 for WIDTH=32.
  - Latency is fixed and does not depend on the data.
- busy rises the cycle after an accepted start and falls the cycle done rises.
- P changes only on the FIX→DONE edge and on reset.
- Back-to-back: start during DONE gives done pulses exactly WIDTH+2 cycles apart.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package muldiv_pkg holds:
  - the WIDTH default constant, also used by the divider;
  - the state typedef enum {IDLE, RUN, FIX, DONE};
  - a function abs_mag(x, is_signed) returning the WIDTH-bit magnitude.
- Single module with no sub-module. The datapath is one WIDTH+1-bit adder plus one 2*WIDTH-bit negator in FIX.
- The counter is $clog2(WIDTH) bits wide.

## Test plan
- Unsigned: A=0xFFFFFFFF, B=0xFFFFFFFF, is_signed=0 → P=0xFFFFFFFE00000001, done at cycle 34, busy high for cycles 1–33.
- Signed edge: A=0x80000000, B=0x80000000, is_signed=1 → P=0x4000000000000000. Also A=0x80000000, B=1 → P=0xFFFFFFFF80000000.
- Signed mixed: A=-7 (0xFFFFFFF9), B=6 → P=0xFFFFFFFFFFFFFFD6. The same operands with is_signed=0 → P=0x00000005FFFFFFD6.
- Handshake: start pulsed again at cycles 5 and 20 with different operands → ignored; the first result is unchanged. Start held during DONE → second done exactly 34 cycles after the first.
- Reset at cycle 10 of an operation → busy=0, P=0, no done pulse. A new op 3×5 then yields P=15.
- Randomized: 10k random signed and unsigned pairs checked against a 64-bit reference product, with operands toggled during RUN.
